d16_uart: RTL

D16_UART -- requirements
Module: d16_uart

---
 rtl/d16_uart.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/d16_uart.sv
// d16_uart: memory-mapped 8N1 UART for the d16 CPU bus.
// Four word registers at BASE_ADDR: DATA, STATUS, CTRL, and a reserved word.
// TX side: 4-entry FIFO feeding a shifter. RX side: 2-flop synchronizer,
// sampling state machine, and a single-byte holding register.
//
// TX states
//   state    | meaning
//   TX_IDLE  | line high, waiting for the FIFO to hold a byte
//   TX_START | driving the start bit (0) for CLKDIV cycles
//   TX_DATA  | driving 8 data bits LSB first, CLKDIV cycles each
//   TX_STOP  | driving the stop bit (1); chains straight into START if more is queued
//
// RX states
//   state    | meaning
//   RX_IDLE  | waiting for a 1->0 edge on the synchronized line
//   RX_START | half a bit in; a high line here is a false start
//   RX_DATA  | sampling 8 data bits, one every CLKDIV cycles
//   RX_STOP  | sampling the stop bit; high delivers the byte, low drops it
module d16_uart #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter logic [15:0] CLKDIV    = 16'd104
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_wb_addr,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [15:0] i_wb_dat,
  output logic [15:0] o_wb_dat,
  output logic        o_int,
  output logic        o_tx,
  input  logic        i_rx
);

  localparam logic [15:0] BIT_LAST  = CLKDIV - 16'd1;
  localparam logic [15:0] HALF_LAST = (CLKDIV >> 1) - 16'd1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // bus decode
  logic       sel, wr, rd;
  logic [1:0] off;
  logic       wr_data, rd_data, wr_status, wr_ctrl;
  logic       unused_dat;

  assign sel       = i_wb_cyc & (i_wb_addr[15:2] == BASE_ADDR[15:2]);
  assign wr        = sel & i_wb_we;
  assign rd        = sel & ~i_wb_we;
  assign off       = i_wb_addr[1:0];
  assign wr_data   = wr & (off == 2'd0);
  assign rd_data   = rd & (off == 2'd0);
  assign wr_status = wr & (off == 2'd1);
  assign wr_ctrl   = wr & (off == 2'd2);
  assign unused_dat = ^i_wb_dat[15:8];

  // TX FIFO
  logic [7:0] tx_mem [4];
  logic [1:0] tx_wptr, tx_rptr;
  logic [2:0] tx_count;
  logic       tx_full, tx_empty, tx_push, tx_pop;

  // TX shifter
  tx_state_t  tx_state, tx_state_nxt;
  logic [15:0] tx_cnt, tx_cnt_nxt;
  logic [2:0] tx_bit, tx_bit_nxt;
  logic [7:0] tx_shift, tx_shift_nxt;
  logic       tx_idle;

  // RX path
  logic       rx_s1, rx_s2, rx_prev, rx_fall;
  rx_state_t  rx_state, rx_state_nxt;
  logic [15:0] rx_cnt, rx_cnt_nxt;
  logic [2:0] rx_bit, rx_bit_nxt;
  logic [7:0] rx_shift, rx_shift_nxt;
  logic       rx_done;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_overrun;

  logic [1:0] ctrl;

  assign tx_full  = (tx_count == 3'd4);
  assign tx_empty = (tx_count == 3'd0);
  // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
  assign tx_push  = wr_data & (~tx_full | tx_pop);
  assign tx_idle  = tx_empty & (tx_state == TX_IDLE);

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wptr] <= i_wb_dat[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      tx_wptr  <= 2'd0;
      tx_rptr  <= 2'd0;
      tx_count <= 3'd0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 2'd1;
      if (tx_pop)  tx_rptr <= tx_rptr + 2'd1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 3'd1;
        2'b01:   tx_count <= tx_count - 3'd1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // TX state register and shifter datapath
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
    end
  end

  // TX next state: bit timing by down-counter, FIFO pop on frame start
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop       = 1'b1;
          tx_state_nxt = TX_START;
          tx_cnt_nxt   = BIT_LAST;
          tx_shift_nxt = tx_mem[tx_rptr];
        end
      end
      TX_START: begin
        if (tx_cnt == 16'd0) begin
          tx_state_nxt = TX_DATA;
          tx_cnt_nxt   = BIT_LAST;
          tx_bit_nxt   = 3'd0;
        end else begin
          tx_cnt_nxt = tx_cnt - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_nxt = BIT_LAST;
          if (tx_bit == 3'd7) begin
            tx_state_nxt = TX_STOP;
          end else begin
            tx_bit_nxt   = tx_bit + 3'd1;
            tx_shift_nxt = {1'b0, tx_shift[7:1]};
          end
        end else begin
          tx_cnt_nxt = tx_cnt - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == 16'd0) begin
          if (!tx_empty) begin
            tx_pop       = 1'b1;
            tx_state_nxt = TX_START;
            tx_cnt_nxt   = BIT_LAST;
            tx_shift_nxt = tx_mem[tx_rptr];
          end else begin
            tx_state_nxt = TX_IDLE;
          end
        end else begin
          tx_cnt_nxt = tx_cnt - 16'd1;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // serial line level decoded from the shifter state
  always_comb begin
    case (tx_state)
      TX_START: o_tx = 1'b0;
      TX_DATA:  o_tx = tx_shift[0];
      default:  o_tx = 1'b1;
    endcase
  end

  // RX line synchronizer plus one delayed copy for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= i_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  // RX state register and sampling datapath
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  // RX next state: half-bit start check, then full-bit sample spacing
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_done      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_nxt = RX_START;
          rx_cnt_nxt   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt == 16'd0) begin
          if (rx_s2) begin
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_state_nxt = RX_DATA;
            rx_cnt_nxt   = BIT_LAST;
            rx_bit_nxt   = 3'd0;
          end
        end else begin
          rx_cnt_nxt = rx_cnt - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == 16'd0) begin
          rx_shift_nxt = {rx_s2, rx_shift[7:1]};
          rx_cnt_nxt   = BIT_LAST;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
          else                rx_bit_nxt   = rx_bit + 3'd1;
        end else begin
          rx_cnt_nxt = rx_cnt - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == 16'd0) begin
          rx_done      = rx_s2;
          rx_state_nxt = RX_IDLE;
        end else begin
          rx_cnt_nxt = rx_cnt - 16'd1;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX holding register and flags; a read landing with a new byte lets it through
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rx_byte    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr_status && i_wb_dat[3]) rx_overrun <= 1'b0;
      if (rx_done) begin
        if (rx_valid && !rd_data) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_byte  <= rx_shift;
          rx_valid <= 1'b1;
        end
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // control register
  always_ff @(posedge i_clk) begin
    if (!i_reset)     ctrl <= 2'b00;
    else if (wr_ctrl) ctrl <= i_wb_dat[1:0];
  end

  // registered interrupt request
  always_ff @(posedge i_clk) begin
    if (!i_reset) o_int <= 1'b0;
    else          o_int <= (rx_valid & ctrl[0]) | (tx_idle & ctrl[1]);
  end

  // combinational read mux
  always_comb begin
    o_wb_dat = 16'h0000;
    if (rd) begin
      case (off)
        2'd0:    o_wb_dat = {8'h00, rx_byte};
        2'd1:    o_wb_dat = {11'd0, tx_idle, rx_overrun, tx_empty, tx_full, rx_valid};
        2'd2:    o_wb_dat = {14'd0, ctrl};
        default: o_wb_dat = 16'h0000;
      endcase
    end
  end

endmodule
